// File: rtl/priority_grant_decoder.sv
// rtl/priority_grant_decoder.sv - registered one-hot grant decoder with hold window and recovery gap
// Optional grant counter: define PRIORITY_GRANT_DECODER_CNT_EN to add the grant_cnt port.
module priority_grant_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] enc_idx,
  input  logic       enc_valid,
  output logic       enc_ready,
  input  logic       release_i,
  output logic [3:0] grant,
  output logic       grant_valid
`ifdef PRIORITY_GRANT_DECODER_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Counter reload value: the first GRANT cycle is counted by the load itself.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || CNT_W < 1) begin : g_bad_params
    $error("priority_grant_decoder: HOLD_CYCLES must be 1..255 and CNT_W >= 1");
  end

  state_t     state_q;
  state_t     state_d;
  logic [1:0] idx_q;
  logic [7:0] hold_q;
  logic       accept;
  logic       grant_done;

  // enc_ready is exactly "state is IDLE", so acceptance needs only enc_valid there.
  assign accept     = (state_q == S_IDLE) && enc_valid;
  // Release and counter expiry collapse into one exit condition: no double event.
  assign grant_done = (hold_q == 8'd0) || release_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, hold or release in GRANT, single recovery cycle in GAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enc_valid) state_d = S_GRANT;
      S_GRANT: if (grant_done) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Captured winner index and hold-window down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      hold_q <= 8'd0;
    end else if (accept) begin
      idx_q  <= enc_idx;
      hold_q <= HOLD_LOAD;
    end else if ((state_q == S_GRANT) && !grant_done) begin
      hold_q <= hold_q - 8'd1;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally
  always_comb begin
    enc_ready   = (state_q == S_IDLE);
    grant_valid = (state_q == S_GRANT);
    grant       = grant_valid ? (4'b0001 << idx_q) : 4'b0000;
  end

`ifdef PRIORITY_GRANT_DECODER_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of accepted grants, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (accept && (grant_cnt != CNT_MAX)) begin
      grant_cnt <= grant_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_priority_grant_decoder.sv
// tb/tb_priority_grant_decoder.sv - self-checking bench for priority_grant_decoder
module tb_priority_grant_decoder;

  localparam int HOLD = 4;
  localparam int CW   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] enc_idx = 2'd0;
  logic       enc_valid = 1'b0;
  logic       release_i = 1'b0;
  logic       enc_ready;
  logic [3:0] grant;
  logic       grant_valid;
  logic       enc_ready1;
  logic [3:0] grant1;
  logic       grant_valid1;
`ifdef PRIORITY_GRANT_DECODER_CNT_EN
  logic [CW-1:0] grant_cnt;
  logic [7:0]    grant_cnt1;
`endif

  priority_grant_decoder #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .enc_idx(enc_idx), .enc_valid(enc_valid),
    .enc_ready(enc_ready), .release_i(release_i), .grant(grant), .grant_valid(grant_valid)
`ifdef PRIORITY_GRANT_DECODER_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  priority_grant_decoder #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enc_idx(enc_idx), .enc_valid(enc_valid),
    .enc_ready(enc_ready1), .release_i(release_i), .grant(grant1), .grant_valid(grant_valid1)
`ifdef PRIORITY_GRANT_DECODER_CNT_EN
    , .grant_cnt(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: cycles of grant still to show, a pending recovery cycle, chosen line
  int m_left = 0;
  bit m_gap  = 1'b0;
  int m_idx  = 0;

  function automatic logic [3:0] exp_grant();
    return (m_left > 0) ? 4'(1 << m_idx) : 4'b0000;
  endfunction

  function automatic bit exp_ready();
    return (m_left == 0) && !m_gap;
  endfunction

  task automatic model_reset();
    m_left = 0;
    m_gap  = 1'b0;
    m_idx  = 0;
  endtask

  // Drive inputs for one cycle, advance the model at the edge, return at the next negedge
  task automatic tick(input bit v, input int idx, input bit rel);
    enc_valid = v;
    enc_idx   = 2'(idx);
    release_i = rel;
    @(posedge clk);
    if (m_left > 0) begin
      if (rel || m_left == 1) begin
        m_left = 0;
        m_gap  = 1'b1;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (v) begin
      m_left = HOLD;
      m_idx  = idx;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && !exp_ready(); i++) tick(0, 0, 0);
    repeat (3) tick(0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || enc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: grant=%b valid=%b ready=%b, want 0000 0 1", grant, grant_valid, enc_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, $urandom_range(0, 3), $urandom_range(0, 1));
      n_tests++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || enc_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_%0d: grant=%b valid=%b ready=%b, want 0000 0 1", i, grant, grant_valid, enc_ready);
      end
    end
  endtask

  task automatic test_basic();
    tick(1, 2, 0);
    for (int k = 0; k < HOLD; k++) begin
      n_tests++;
      if (grant !== 4'b0100 || grant_valid !== 1'b1 || enc_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_grant_%0d: grant=%b valid=%b ready=%b, want 0100 1 0", k, grant, grant_valid, enc_ready);
      end
      tick(0, 0, 0);
    end
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || enc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_gap: grant=%b valid=%b ready=%b, want 0000 0 0", grant, grant_valid, enc_ready);
    end
    tick(0, 0, 0);
    n_tests++;
    if (enc_ready !== 1'b1 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_idle: grant=%b ready=%b, want 0000 1", grant, enc_ready);
    end
  endtask

  task automatic test_release();
    tick(1, 3, 0);
    n_tests++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL release_c1: grant=%b, want 1000", grant);
    end
    tick(0, 1, 0);
    n_tests++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL release_c2: grant=%b, want 1000", grant);
    end
    tick(0, 1, 1);
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || enc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL release_gap: grant=%b valid=%b ready=%b, want 0000 0 0", grant, grant_valid, enc_ready);
    end
    tick(0, 0, 1);
    n_tests++;
    if (enc_ready !== 1'b1 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL release_idle: grant=%b ready=%b, want 0000 1", grant, enc_ready);
    end
  endtask

  task automatic test_back_to_back();
    int first_vis;
    int second_vis;
    tick(1, 0, 0);
    first_vis = cyc;
    for (int k = 0; k < HOLD; k++) begin
      n_tests++;
      if (grant !== 4'b0001) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: grant=%b, want 0001", k, grant);
      end
      tick(1, 1, 0);
    end
    second_vis = -1;
    for (int i = 0; i < 10 && second_vis < 0; i++) begin
      if (grant === 4'b0010) second_vis = cyc;
      else tick(1, 1, 0);
    end
    n_tests++;
    if (second_vis - first_vis !== HOLD + 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, want %0d", second_vis - first_vis, HOLD + 2);
    end
    drain();
  endtask

  task automatic test_hold_one();
    tick(1, 1, 0);
    n_tests++;
    if (grant1 !== 4'b0010 || grant_valid1 !== 1'b1) begin
      n_fail++;
      $display("FAIL hold1_grant: grant=%b valid=%b, want 0010 1", grant1, grant_valid1);
    end
    tick(0, 0, 1);
    n_tests++;
    if (grant1 !== 4'b0000 || enc_ready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL hold1_gap: grant=%b ready=%b, want 0000 0", grant1, enc_ready1);
    end
    tick(0, 0, 0);
    n_tests++;
    if (enc_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL hold1_idle: ready=%b, want 1", enc_ready1);
    end
    drain();
  endtask

  task automatic test_async_reset();
    tick(1, 1, 0);
    tick(0, 0, 0);
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL areset_pre: grant=%b, want 0010", grant);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: grant=%b valid=%b, want 0000 0", grant, grant_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_tests++;
    if (enc_ready !== 1'b1 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_after: grant=%b ready=%b, want 0000 1", grant, enc_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      n_tests++;
      if (grant !== exp_grant() || grant_valid !== (m_left > 0) || enc_ready !== exp_ready()) begin
        n_fail++;
        $display("FAIL random_%0d: grant=%b valid=%b ready=%b, want %b %b %b",
                 i, grant, grant_valid, enc_ready, exp_grant(), (m_left > 0), exp_ready());
      end
    end
    drain();
  endtask

`ifdef PRIORITY_GRANT_DECODER_CNT_EN
  task automatic test_counter();
    int exp_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_tests++;
    if (grant_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_reset: grant_cnt=%0d, want 0", grant_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, i % 4, 0);
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      n_tests++;
      if (grant_cnt !== CW'(exp_cnt)) begin
        n_fail++;
        $display("FAIL cnt_%0d: grant_cnt=%0d, want %0d", i, grant_cnt, exp_cnt);
      end
      tick(0, 0, 1);
      tick(0, 0, 0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_release();
    test_back_to_back();
    test_hold_one();
    test_async_reset();
    test_random();
`ifdef PRIORITY_GRANT_DECODER_CNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_grant_decoder.md
Name: priority_grant_decoder

Overview:
- Consumer-side counterpart of the 4-line priority encoder.
- Accepts a 2-bit encoded winner index plus valid and drives a registered one-hot grant back to the selected requester line for a programmable hold window.
- A one-cycle recovery gap follows each grant.
- Sits between the request encoder and the four requester ports; it closes the request/grant loop.

Parameters:
HOLD_CYCLES, 4, grant hold length in clock cycles; legal range 1..255
CNT_W, 8, width of the accepted-grant counter (used only when the optional feature is enabled)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
enc_idx  input  2  encoded winning line index, 0..3
enc_valid  input  1  enc_idx is valid (encoder "any request" output)
enc_ready  output  1  decoder can accept a new index this cycle
release_i  input  1  early release from the granted requester
grant  output  4  one-hot grant, bit n = line n
grant_valid  output  1  a grant is active
grant_cnt  output  CNT_W  number of accepted grants (present only with the optional feature)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Every output is a register or a pure decode of the state register. There is no combinational path from any input to any output.
- Reset values:
  - state = IDLE
  - grant = 4'b0000, grant_valid = 0, enc_ready = 1
  - internal hold counter = 0, captured index = 0, grant_cnt = 0
- Reset asserted mid-operation clears everything immediately, asynchronously. The first cycle after deassertion is IDLE.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - enc_ready = 1.
  - Acceptance occurs on a rising edge where enc_valid = 1 and enc_ready = 1. On that edge: capture enc_idx, set grant = 1 << enc_idx, set grant_valid = 1, load the hold counter with HOLD_CYCLES-1, go to GRANT.
  - Latency from the accepting edge to grant visible is 1 clock.
- GRANT:
  - enc_ready = 0. grant stays constant with exactly one bit set.
  - Each edge, if counter == 0 or release_i == 1: clear grant to 0, clear grant_valid, go to GAP. Otherwise decrement the counter.
  - Without release, grant is high for exactly HOLD_CYCLES cycles.
  - If release_i is high in the first GRANT cycle, grant is high for exactly 1 cycle.
- GAP:
  - Lasts exactly 1 cycle. enc_ready = 0, grant = 0. Then go to IDLE.
- Throughput: at most one grant per HOLD_CYCLES+2 cycles when enc_valid is held continuously.
- No buffering:
  - enc_valid/enc_idx presented while enc_ready = 0 are ignored, not queued. The requester holds its request until it is accepted.
  - enc_idx changing during GRANT has no effect on grant.
- release_i is ignored in IDLE and GAP.
- release_i and counter reaching 0 on the same edge: single exit to GAP, no double event.
- HOLD_CYCLES = 1: grant lasts 1 cycle; release_i is irrelevant.
- The one-hot invariant always holds: grant is either 0 or has exactly one bit set, and grant_valid == |grant.

Optional Feature:
- Macro: PRIORITY_GRANT_DECODER_CNT_EN
- Defined:
  - grant_cnt port exists.
  - Increments by 1 on every acceptance edge (IDLE with enc_valid = 1).
  - Saturates at all-ones and never wraps.
  - Cleared only by rst_n.
- Undefined: the grant_cnt port and its counter logic are absent entirely. All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n = 0 for 3 cycles, release -> grant = 0000, grant_valid = 0, enc_ready = 1; with enc_valid = 0 for 10 cycles, all three are unchanged.
- Basic grant, HOLD_CYCLES = 4: enc_idx = 2, enc_valid = 1 for one cycle in IDLE -> next cycle grant = 0100 for exactly 4 cycles, then 1 GAP cycle with grant = 0000 and enc_ready = 0, then enc_ready = 1.
- Early release: enc_idx = 3 accepted; release_i = 1 in the 2nd grant cycle -> grant = 1000 for exactly 2 cycles, then GAP, then IDLE.
- Back-to-back and ignored inputs: enc_valid held at 1, enc_idx switching 0 -> 1 during GRANT -> grant stays 0001 for the full window; the next grant is 0010, starting HOLD_CYCLES+2 cycles after the first.
- Async reset mid-grant: assert rst_n = 0 in the 2nd GRANT cycle, between clock edges -> grant = 0000 and grant_valid = 0 immediately, without waiting for an edge; after release, enc_ready = 1.
- Counter (macro defined, CNT_W = 2): 5 accepted grants -> grant_cnt reads 1, 2, 3, 3, 3; with the macro undefined, the design elaborates without the grant_cnt port.
